// File: rtl/hazard_mc.sv
// Pipeline hazard controller: N-slot decode forwarding with load-use detection,
// a multicycle mul/div handshake FSM, per-stage stall/flush and a stall counter.
module hazard_mc #(
  parameter int NUM_FWD = 3,
  parameter int FW      = $clog2(NUM_FWD + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rsD,
  input  logic [4:0]           rtD,
  input  logic [NUM_FWD*5-1:0] src_reg,
  input  logic [NUM_FWD-1:0]   src_we,
  input  logic [NUM_FWD-1:0]   src_pend,
  output logic [FW-1:0]        fwdaD,
  output logic [FW-1:0]        fwdbD,
  input  logic                 md_opE,
  input  logic                 md_ready,
  output logic                 md_start,
  output logic                 md_cancel,
  output logic                 md_busy,
  input  logic                 exc_valid,
  input  logic                 stallreq_if,
  input  logic                 stallreq_mem,
  output logic [4:0]           stall,
  output logic [4:0]           flush,
  output logic [31:0]          stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } md_state_e;

  md_state_e   r_state;
  logic [31:0] r_stall_cnt;

  logic [FW-1:0] w_fwda;
  logic [FW-1:0] w_fwdb;
  logic          w_pend_a;
  logic          w_pend_b;
  logic          w_ld_stall;
  logic          w_md_stall;
  logic          w_in_op;
  logic          w_front;
  logic [4:0]    w_stall;
  logic [4:0]    w_flush;

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_fwda   = '0;
    w_fwdb   = '0;
    w_pend_a = 1'b0;
    w_pend_b = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (rsD != 5'd0 && src_we[i] && src_reg[5*i +: 5] == rsD) begin
        w_fwda   = FW'(i + 1);
        w_pend_a = src_pend[i];
      end
      if (rtD != 5'd0 && src_we[i] && src_reg[5*i +: 5] == rtD) begin
        w_fwdb   = FW'(i + 1);
        w_pend_b = src_pend[i];
      end
    end
  end

  assign w_ld_stall = w_pend_a | w_pend_b;
  assign w_in_op    = (r_state == S_START) || (r_state == S_WAIT);
  assign w_md_stall = ((r_state == S_IDLE) && md_opE) || w_in_op;
  assign w_front    = w_ld_stall | w_md_stall | stallreq_if | stallreq_mem;

  // Reset forces a full flush; a committed exception flushes and releases all stalls.
  always_comb begin
    w_stall = '0;
    w_flush = '0;
    if (rst || exc_valid) begin
      w_flush = 5'b11111;
    end else begin
      w_stall = {1'b0, stallreq_mem, w_md_stall | stallreq_mem, w_front, w_front};
      w_flush = {stallreq_mem, 1'b0, w_ld_stall & ~w_md_stall & ~stallreq_mem, 1'b0, 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state     <= S_IDLE;
      r_stall_cnt <= '0;
    end else begin
      if (w_stall[1]) r_stall_cnt <= r_stall_cnt + 32'd1;
      case (r_state)
        S_IDLE:  if (md_opE && !exc_valid) r_state <= S_START;
        S_START: r_state <= exc_valid ? S_IDLE : S_WAIT;
        S_WAIT: begin
          if (exc_valid)     r_state <= S_IDLE;
          else if (md_ready) r_state <= S_DONE;
        end
        // Held here while memory stalls so the op is never relaunched.
        S_DONE:  if (!stallreq_mem) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fwdaD     = w_fwda;
  assign fwdbD     = w_fwdb;
  assign md_start  = ~rst & (r_state == S_START) & ~exc_valid;
  assign md_cancel = ~rst & w_in_op & exc_valid;
  assign md_busy   = ~rst & (r_state != S_IDLE);
  assign stall     = w_stall;
  assign flush     = w_flush;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_mc.sv
// Scoreboard bench for hazard_mc: directed scenarios then random traffic, each
// cycle's expectation queued by the driver and popped by a negedge monitor.
module tb_hazard_mc;

  localparam int N  = 3;
  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rsD, rtD;
  logic [N*5-1:0] src_reg;
  logic [N-1:0]  src_we, src_pend;
  logic [FW-1:0] fwdaD, fwdbD;
  logic          md_opE, md_ready, md_start, md_cancel, md_busy;
  logic          exc_valid, stallreq_if, stallreq_mem;
  logic [4:0]    stall, flush;
  logic [31:0]   stall_cnt;

  hazard_mc #(.NUM_FWD(N)) dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD),
    .src_reg(src_reg), .src_we(src_we), .src_pend(src_pend),
    .fwdaD(fwdaD), .fwdbD(fwdbD),
    .md_opE(md_opE), .md_ready(md_ready),
    .md_start(md_start), .md_cancel(md_cancel), .md_busy(md_busy),
    .exc_valid(exc_valid), .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .stall(stall), .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] fa, fb;
    logic          start, cancel, busy;
    logic [4:0]    stall, flush;
    logic [31:0]   cnt;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: the mul/div unit as three activity flags.
  bit          m_kick, m_run, m_hold;
  logic [31:0] m_cnt;
  bit          m_last_front = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] ref_fwd(input logic [4:0] x);
    if (x == 5'd0) return '0;
    for (int i = 0; i < N; i++)
      if (src_we[i] && src_reg[5*i +: 5] == x) return FW'(i + 1);
    return '0;
  endfunction

  task automatic sample();
    exp_t e;
    bit ld, md, idle, front;
    e.fa  = ref_fwd(rsD);
    e.fb  = ref_fwd(rtD);
    ld    = (e.fa != 0 && src_pend[int'(e.fa) - 1]) || (e.fb != 0 && src_pend[int'(e.fb) - 1]);
    idle  = !(m_kick || m_run || m_hold);
    md    = (idle && md_opE) || m_kick || m_run;
    front = ld || md || stallreq_if || stallreq_mem;
    e.cnt = m_cnt;
    if (rst) begin
      e.start = 0; e.cancel = 0; e.busy = 0;
      e.stall = 5'b00000; e.flush = 5'b11111;
    end else begin
      e.start  = m_kick && !exc_valid;
      e.cancel = (m_kick || m_run) && exc_valid;
      e.busy   = !idle;
      if (exc_valid) begin
        e.stall = 5'b00000; e.flush = 5'b11111;
      end else begin
        e.stall = {1'b0, stallreq_mem, md || stallreq_mem, front, front};
        e.flush = {stallreq_mem, 1'b0, ld && !md && !stallreq_mem, 1'b0, 1'b0};
      end
    end
    m_last_front = !rst && e.stall[1];
    q.push_back(e);
  endtask

  task automatic model_step();
    if (rst) begin
      m_kick = 0; m_run = 0; m_hold = 0; m_cnt = 32'd0;
    end else begin
      if (m_last_front) m_cnt = m_cnt + 32'd1;
      if (m_kick) begin
        m_kick = 0; m_run = !exc_valid;
      end else if (m_run) begin
        if (exc_valid) m_run = 0;
        else if (md_ready) begin m_run = 0; m_hold = 1; end
      end else if (m_hold) begin
        if (!stallreq_mem) m_hold = 0;
      end else if (md_opE && !exc_valid) begin
        m_kick = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("fwdaD", 32'(fwdaD), 32'(e.fa));
        check("fwdbD", 32'(fwdbD), 32'(e.fb));
        check("md_start", 32'(md_start), 32'(e.start));
        check("md_cancel", 32'(md_cancel), 32'(e.cancel));
        check("md_busy", 32'(md_busy), 32'(e.busy));
        check("stall", 32'(stall), 32'(e.stall));
        check("flush", 32'(flush), 32'(e.flush));
        check("stall_cnt", stall_cnt, e.cnt);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst = 1; rsD = 0; rtD = 0; src_reg = '0; src_we = '0; src_pend = '0;
    md_opE = 0; md_ready = 0; exc_valid = 0; stallreq_if = 0; stallreq_mem = 0;
    tick(); sample();
    tick(); sample(); #1;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_flush", 32'(flush), 32'h1f);
    check("rst_busy", 32'(md_busy), 32'h0);

    // Forwarding priority
    tick(); rst = 0; rsD = 5; src_reg = {5'd5, 5'd9, 5'd5}; src_we = 3'b101; sample(); #1;
    check("fwd_youngest", 32'(fwdaD), 32'd1);
    tick(); src_we = 3'b100; sample(); #1;
    check("fwd_oldest", 32'(fwdaD), 32'd3);
    tick(); rsD = 0; sample(); #1;
    check("fwd_r0", 32'(fwdaD), 32'd0);

    // Load-use
    tick(); rsD = 1; rtD = 8; src_reg = {5'd0, 5'd0, 5'd8}; src_we = 3'b001; src_pend = 3'b001;
    sample(); #1;
    check("lduse_stall", 32'(stall), 32'b00011);
    check("lduse_flushE", 32'(flush[2]), 32'd1);
    tick(); src_pend = 3'b000; sample(); #1;
    check("lduse_fwdb", 32'(fwdbD), 32'd1);
    check("lduse_clear", 32'(stall), 32'd0);

    // Multicycle op: opE at c0, ready at c10
    tick(); src_we = '0; md_opE = 1; sample(); #1;
    check("md_stallE_c0", 32'(stall[2]), 32'd1);
    for (int c = 1; c <= 10; c++) begin
      tick(); md_ready = (c == 10); sample(); #1;
      check("md_start_pulse", 32'(md_start), 32'(c == 1));
      check("md_stallE", 32'(stall[2]), 32'd1);
    end
    tick(); md_ready = 0; md_opE = 0; sample(); #1;
    check("md_done_busy", 32'(md_busy), 32'd1);
    check("md_done_release", 32'(stall[2]), 32'd0);
    tick(); sample(); #1;
    check("md_idle", 32'(md_busy), 32'd0);

    // Exception cancels in WAIT
    tick(); md_opE = 1; sample();
    for (int c = 1; c <= 3; c++) begin tick(); sample(); end
    tick(); exc_valid = 1; sample(); #1;
    check("exc_cancel", 32'(md_cancel), 32'd1);
    check("exc_stall", 32'(stall), 32'd0);
    check("exc_flush", 32'(flush), 32'h1f);
    tick(); exc_valid = 0; md_opE = 0; sample(); #1;
    check("exc_idle", 32'(md_busy), 32'd0);

    // Memory stall holds DONE
    tick(); md_opE = 1; sample();
    tick(); sample();
    tick(); md_ready = 1; sample();
    for (int c = 0; c < 3; c++) begin
      tick(); md_ready = 0; stallreq_mem = 1; sample(); #1;
      check("done_hold_busy", 32'(md_busy), 32'd1);
      check("done_no_restart", 32'(md_start), 32'd0);
    end
    tick(); stallreq_mem = 0; md_opE = 0; sample();
    tick(); sample(); #1;
    check("done_exit", 32'(md_busy), 32'd0);

    // Stall counter, reset and wrap
    tick(); rst = 1; sample();
    tick(); rst = 0; stallreq_if = 1; sample();
    for (int c = 0; c < 6; c++) begin tick(); sample(); end
    tick(); stallreq_if = 0; rst = 1; sample(); #1;
    check("cnt_seven", stall_cnt, 32'd7);
    tick(); rst = 0; sample(); #1;
    check("cnt_reset", stall_cnt, 32'd0);
    tick(); stallreq_if = 1;
    force dut.r_stall_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_stall_cnt;
    m_cnt = 32'hFFFF_FFFF;
    sample();
    tick(); stallreq_if = 0; sample(); #1;
    check("cnt_wrap", stall_cnt, 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst          = ($urandom_range(99) == 0);
      rsD          = 5'($urandom_range(7));
      rtD          = 5'($urandom_range(7));
      for (int i = 0; i < N; i++) src_reg[5*i +: 5] = 5'($urandom_range(7));
      src_we       = N'($urandom);
      src_pend     = N'($urandom);
      md_opE       = ($urandom_range(9) < 3);
      md_ready     = ($urandom_range(9) < 2);
      exc_valid    = ($urandom_range(19) == 0);
      stallreq_if  = ($urandom_range(9) == 0);
      stallreq_mem = ($urandom_range(9) == 0);
      sample();
    end

    @(negedge clk); #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
